reg_cmd_master: RTL and testbench

// Byte-stream command initiator for the single-register peripheral bus (rd_en/wr_en/data_in/data_out).
// - Consumes command bytes from a host byte source (SPI/UART RX) over a valid/ready stream.
// - Decodes each command and drives one-hot per-peripheral rd_en/wr_en strobes.
// - Captures read data and returns it on a valid/ready response stream (host TX).
// - Sits between the host link and the LED/config peripherals.

---
 rtl/reg_bus_pkg.sv | 23 ++
 rtl/reg_cmd_master.sv | 131 +++++++++++++
 tb/tb_reg_cmd_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the single-register peripheral bus command master.
// Command byte layout: bit7 selects write, low bits carry the peripheral address.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WSTB,
        RSTB,
        RWAIT,
        RSP
    } state_t;

    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_ADDR_W  = 7;
    localparam int BAD_RD_DATA = 0;

    // Any address at or beyond the peripheral count, including nonzero upper bits, is invalid.
    function automatic logic addr_valid(input logic [CMD_ADDR_W-1:0] addr, input int num_periph);
        return int'(addr) < num_periph;
    endfunction

endpackage

// File: rtl/reg_cmd_master.sv
// Byte-stream command initiator: decodes host command bytes into one-hot peripheral
// read/write strobes and returns captured read data on a valid/ready response stream.
module reg_cmd_master
    import reg_bus_pkg::*;
#(
    parameter int NUM_PERIPH = 4,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            cmd_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NUM_PERIPH-1:0]        per_rd_en,
    output logic [NUM_PERIPH-1:0]        per_wr_en,
    output logic [DATA_W-1:0]            per_wdata,
    input  logic [NUM_PERIPH*DATA_W-1:0] per_rdata,
    output logic                         bad_addr
);

    localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    state_t                  state_q, state_d;
    logic [CMD_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    addr_ok;
    logic                    accept;
    logic [NUM_PERIPH-1:0]   addr_dec;
    logic [DATA_W-1:0]       sel_rdata;

    assign addr_ok   = addr_valid(addr_q, NUM_PERIPH);
    assign accept    = cmd_valid && cmd_ready;
    assign per_wdata = wdata_q;
    assign rsp_data  = rdata_q;

    // One-hot address decode and read-data mux share the same compare.
    always_comb begin
        addr_dec  = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (int'(addr_q) == i) begin
                addr_dec[i] = 1'b1;
                sel_rdata   = per_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == IDLE)
                addr_q <= cmd_data[CMD_ADDR_W-1:0];
            if (accept && state_q == WDATA)
                wdata_q <= cmd_data;
            case (state_q)
                RSTB: begin
                    cnt_q <= CNT_W'(RD_LAT);
                    if (!addr_ok)
                        rdata_q <= DATA_W'(BAD_RD_DATA);
                    else if (RD_LAT == 0)
                        rdata_q <= sel_rdata;
                end
                RWAIT: begin
                    // Capture on the cycle the count reaches zero.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1))
                        rdata_q <= sel_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        per_rd_en = '0;
        per_wr_en = '0;
        bad_addr  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = cmd_data[CMD_WR_BIT] ? WDATA : RSTB;
            end
            WDATA: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = WSTB;
            end
            WSTB: begin
                if (addr_ok) per_wr_en = addr_dec;
                else         bad_addr  = 1'b1;
                state_d = IDLE;
            end
            RSTB: begin
                if (addr_ok) begin
                    per_rd_en = addr_dec;
                    state_d   = (RD_LAT == 0) ? RSP : RWAIT;
                end else begin
                    bad_addr = 1'b1;
                    state_d  = RSP;
                end
            end
            RWAIT: begin
                if (cnt_q <= CNT_W'(1))
                    state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: an RD_LAT=1 instance driven from a vector table with a
// response scoreboard, plus an RD_LAT=3 instance for the mid-read reset sequence.
module tb_reg_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset3;
    logic [7:0]  cmd_data;
    logic        cmd_valid, rsp_ready;

    logic        cmd_ready, rsp_valid, bad_addr;
    logic [7:0]  rsp_data, per_wdata;
    logic [3:0]  per_rd_en, per_wr_en;
    logic [31:0] per_rdata;

    logic        cmd_ready3, rsp_valid3, bad_addr3;
    logic [7:0]  rsp_data3, per_wdata3;
    logic [3:0]  per_rd_en3, per_wr_en3;
    logic [31:0] per_rdata3;

    reg_cmd_master #(.NUM_PERIPH(4), .DATA_W(8), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .per_rd_en(per_rd_en), .per_wr_en(per_wr_en),
        .per_wdata(per_wdata), .per_rdata(per_rdata), .bad_addr(bad_addr)
    );

    reg_cmd_master #(.NUM_PERIPH(4), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready3), .rsp_data(rsp_data3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready), .per_rd_en(per_rd_en3), .per_wr_en(per_wr_en3),
        .per_wdata(per_wdata3), .per_rdata(per_rdata3), .bad_addr(bad_addr3)
    );

    // Peripheral models: registered data_out, valid only RD_LAT cycles after rd_en.
    logic [7:0] pmem1 [4] = '{8'h0F, 8'h1E, 8'hA5, 8'h4B};
    logic [7:0] pmem3 [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] rdh1;
    logic [3:0] rdh3 [3];

    always @(posedge clk) begin
        rdh1    <= per_rd_en;
        rdh3[0] <= per_rd_en3;
        rdh3[1] <= rdh3[0];
        rdh3[2] <= rdh3[1];
        for (int i = 0; i < 4; i++) begin
            if (per_wr_en[i])  pmem1[i] <= per_wdata;
            if (per_wr_en3[i]) pmem3[i] <= per_wdata3;
        end
    end

    always_comb begin
        per_rdata  = '1;
        per_rdata3 = '1;
        for (int i = 0; i < 4; i++) begin
            per_rdata[i*8 +: 8]  = rdh1[i]    ? pmem1[i] : 8'hEE;
            per_rdata3[i*8 +: 8] = rdh3[2][i] ? pmem3[i] : 8'hEE;
        end
    end

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the RD_LAT=1 instance: strobe bookkeeping and response scoreboard.
    logic [31:0] sb [$];
    int   n_wr = 0, n_rd = 0, n_bad = 0;
    int   wr_cyc = 0, rd_cyc = 0, acc_cyc = 0, rsp_cyc = 0;
    logic [3:0] last_wr = '0, last_rd = '0;
    logic rsp_v_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if ((per_wr_en | per_rd_en) != 4'b0)
                chk("strobe_onehot", 32'($onehot({per_rd_en, per_wr_en})), 32'd1);
            if (|per_wr_en) begin n_wr++; wr_cyc = cyc; last_wr = per_wr_en; end
            if (|per_rd_en) begin n_rd++; rd_cyc = cyc; last_rd = per_rd_en; end
            if (bad_addr) n_bad++;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rsp_valid && !rsp_v_prev) rsp_cyc = cyc;
            if (rsp_valid && rsp_ready)
                chk("rsp_data", 32'(rsp_data), (sb.size() > 0) ? sb.pop_front() : 32'h100);
        end
        rsp_v_prev = rsp_valid && !reset;
    end

    task automatic send_byte(input logic [7:0] b, input bit on3);
        bit ok = 1'b0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = on3 ? cmd_ready3 : cmd_ready;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input bit on3);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = on3 ? cmd_ready3 : cmd_ready;
        end
        @(posedge clk); #1;
        chk("return_idle", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [3:0] ewr;
        logic [3:0] erd;
        int         ebad;
    } vec_t;

    vec_t       tbl [11];
    logic [7:0] exp_mem [4] = '{8'h0F, 8'h1E, 8'hA5, 8'h4B};

    initial begin
        int b_wr, b_rd, b_bad, t_idle, k;
        bit seen;
        logic [6:0] a;

        tbl[0]  = '{8'h81, 8'h3C, 4'b0010, 4'b0000, 0};
        tbl[1]  = '{8'h02, 8'h00, 4'b0000, 4'b0100, 0};
        tbl[2]  = '{8'h83, 8'h77, 4'b1000, 4'b0000, 0};
        tbl[3]  = '{8'h03, 8'h00, 4'b0000, 4'b1000, 0};
        tbl[4]  = '{8'h01, 8'h00, 4'b0000, 4'b0010, 0};
        tbl[5]  = '{8'h80, 8'hC3, 4'b0001, 4'b0000, 0};
        tbl[6]  = '{8'h00, 8'h00, 4'b0000, 4'b0001, 0};
        tbl[7]  = '{8'h85, 8'h11, 4'b0000, 4'b0000, 1};
        tbl[8]  = '{8'h09, 8'h00, 4'b0000, 4'b0000, 1};
        tbl[9]  = '{8'h84, 8'h22, 4'b0000, 4'b0000, 1};
        tbl[10] = '{8'h7F, 8'h00, 4'b0000, 4'b0000, 1};

        cmd_data = '0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        reset = 1'b1; reset3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en",     32'(per_rd_en), 32'd0);
        chk("rst_wr_en",     32'(per_wr_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bad_addr",  32'(bad_addr),  32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_wdata",     32'(per_wdata), 32'd0);
        chk("rst3_cmd_ready", 32'(cmd_ready3), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            b_wr = n_wr; b_rd = n_rd; b_bad = n_bad;
            a = tbl[i].cmd[6:0];
            if (tbl[i].cmd[7]) begin
                if (a < 7'd4) exp_mem[a[1:0]] = tbl[i].dat;
                send_byte(tbl[i].cmd, 1'b0);
                send_byte(tbl[i].dat, 1'b0);
            end else begin
                sb.push_back((a < 7'd4) ? 32'(exp_mem[a[1:0]]) : 32'd0);
                send_byte(tbl[i].cmd, 1'b0);
            end
            wait_idle(1'b0);
            chk("wr_count",  32'(n_wr - b_wr),   32'(tbl[i].ewr != 4'b0));
            chk("rd_count",  32'(n_rd - b_rd),   32'(tbl[i].erd != 4'b0));
            chk("bad_count", 32'(n_bad - b_bad), 32'(tbl[i].ebad));
            if (tbl[i].ewr != 4'b0) begin
                chk("wr_onehot",  32'(last_wr), 32'(tbl[i].ewr));
                chk("wr_latency", 32'(wr_cyc - acc_cyc), 32'd1);
            end
            if (tbl[i].erd != 4'b0) begin
                chk("rd_onehot",   32'(last_rd), 32'(tbl[i].erd));
                chk("rd_latency",  32'(rd_cyc - acc_cyc), 32'd1);
                chk("rsp_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
            end else if (!tbl[i].cmd[7]) begin
                chk("bad_rsp_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
            end
            if (tbl[i].cmd[7]) chk("wdata", 32'(per_wdata), 32'(tbl[i].dat));
            chk("sb_drained", 32'(sb.size()), 32'd0);
        end

        // Response back-pressure, then a queued read accepted straight out of RSP.
        rsp_ready = 1'b0;
        sb.push_back(32'(exp_mem[0]));
        send_byte(8'h00, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("hold_rsp_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        sb.push_back(32'(exp_mem[1]));
        cmd_data = 8'h01; cmd_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data",  32'(rsp_data),  32'h0000_00C3);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        t_idle = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(1'b0);
        chk("b2b_accept", 32'(acc_cyc - t_idle), 32'd0);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

        // Reset during RWAIT on the RD_LAT=3 instance.
        reset = 1'b1; reset3 = 1'b0;
        @(negedge clk);
        chk("r3_cmd_ready", 32'(cmd_ready3), 32'd1);
        @(posedge clk); #1;
        send_byte(8'h02, 1'b1);
        @(negedge clk);
        chk("r3_rd_en", 32'(per_rd_en3), 32'h4);
        @(posedge clk); #1;
        reset3 = 1'b1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t == 0) chk("r3_idle_after_reset", 32'(cmd_ready3), 32'd1);
            seen = seen | rsp_valid3 | (|per_rd_en3) | (|per_wr_en3);
        end
        chk("r3_no_partial_output", 32'(seen), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h80, 1'b1);
        send_byte(8'h5D, 1'b1);
        @(negedge clk);
        chk("r3_wr_en", 32'(per_wr_en3), 32'h1);
        chk("r3_wdata", 32'(per_wdata3), 32'h5D);
        @(negedge clk);
        chk("r3_wr_en_pulse", 32'(per_wr_en3), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h00, 1'b1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = rsp_valid3;
        end
        chk("r3_rsp_latency", 32'(k), 32'd5);
        chk("r3_rsp_data", 32'(rsp_data3), 32'h5D);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
